// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds the FSM encoding, the default reset PC and the FIFO entry width ({pc, instr}).
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    localparam int          DEF_ADDR_W   = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0;

    // A buffered entry carries its PC alongside the 32-bit instruction word.
    function automatic int entry_width(input int addr_w);
        return addr_w + 32;
    endfunction

    localparam int ENTRY_W = entry_width(DEF_ADDR_W);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO whose head comes straight from storage flops, so out_valid and
// out data have no combinational path from push/pop. Flush wins over push.
module fetch_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pop_ok  = pop && (count_q != '0);
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok = push && !flush && ((count_q != CNT_W'(DEPTH)) || pop_ok);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_q] = push_data;
                wr_d        = ptr_inc(wr_q);
            end
            if (pop_ok) begin
                rd_d = ptr_inc(rd_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_data  = mem_q[rd_q];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues reads to a 1-cycle registered
// instruction memory, buffers returns with their PC and serves decode over valid/ready.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC),
    parameter int                MEM_WORDS = 200,
    parameter int                BUF_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_hit,
    input  logic [31:0]       mem_instr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              fault,
    output fetch_state_e      dbg_state
);

    // Handshake: a word moves to decode in any cycle where out_valid && out_ready
    // are both high at the rising edge; out_valid never depends on out_ready and,
    // once raised, out_pc/out_instr hold until that transfer or a redirect/reset.

    localparam int EW    = entry_width(ADDR_W);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tag_pc_q, tag_pc_d;
    logic              inflight_q, inflight_d;
    logic              fault_q, fault_d;

    logic              pc_legal;
    logic              room;
    logic [CNT_W:0]    occupancy;
    logic              issue;
    logic              push;
    logic              flush;
    logic              pop;
    logic [CNT_W-1:0]  fifo_count;
    logic              head_valid;
    logic [EW-1:0]     head_data;

    // Occupancy counts the in-flight read so a slot is reserved before issue.
    always_comb begin
        pc_legal  = (pc_q[1:0] == 2'b00) && ((pc_q >> 2) < ADDR_W'(MEM_WORDS));
        occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);
        room      = occupancy < (CNT_W + 1)'(BUF_DEPTH);
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tag_pc_d   = tag_pc_q;
        inflight_d = 1'b0;
        fault_d    = fault_q;
        issue      = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        if (redirect_valid) begin
            // Redirect discards everything older than the target.
            flush   = 1'b1;
            pc_d    = redirect_pc;
            fault_d = 1'b0;
            state_d = ST_FETCH;
        end else begin
            push = inflight_q;
            case (state_q)
                ST_IDLE: state_d = ST_FETCH;
                ST_FETCH: begin
                    if (room) begin
                        if (pc_legal) begin
                            issue      = 1'b1;
                            pc_d       = pc_q + ADDR_W'(4);
                            tag_pc_d   = pc_q;
                            inflight_d = 1'b1;
                        end else begin
                            state_d = ST_FAULT;
                            fault_d = 1'b1;
                        end
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            tag_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tag_pc_q   <= tag_pc_d;
            inflight_q <= inflight_d;
            fault_q    <= fault_d;
        end
    end

    assign pop = head_valid && out_ready;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  ({tag_pc_q, mem_instr}),
        .pop        (pop),
        .flush      (flush),
        .count      (fifo_count),
        .head_valid (head_valid),
        .head_data  (head_data)
    );

    assign mem_addr  = pc_q;
    assign mem_hit   = issue;
    assign out_valid = head_valid;
    assign out_instr = head_data[31:0];
    assign out_pc    = head_data[EW-1:32];
    assign fault     = fault_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a bench-owned instruction memory, a queue of
// expected {pc, instr} deliveries built from the sequential-fetch rules, and a monitor.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int MEM_WORDS = 200;
    localparam int LIMIT     = MEM_WORDS * 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_addr;
    logic         mem_hit;
    logic [31:0]  mem_instr;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_instr;
    logic [31:0]  out_pc;
    logic         fault;
    fetch_state_e dbg_state;

    logic [31:0]  mem_model [MEM_WORDS];
    logic [63:0]  exp_q [$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [31:0]  last_pc = '1;
    bit           rand_ready = 1'b0;

    fetch_ctrl #(
        .ADDR_W    (32),
        .RESET_PC  (32'h0),
        .MEM_WORDS (MEM_WORDS),
        .BUF_DEPTH (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_hit        (mem_hit),
        .mem_instr      (mem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Registered instruction memory: data for the address seen at an edge appears after it.
    always @(posedge clk) begin
        if (mem_hit) begin
            if ((mem_addr >> 2) < MEM_WORDS) mem_instr <= mem_model[mem_addr >> 2];
            else                             mem_instr <= 32'hdead_beef;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected deliveries after (re)starting at start_pc: every legal word in order.
    task automatic push_seq(input logic [31:0] start_pc);
        for (int a = int'(start_pc); a < LIMIT; a += 4) begin
            exp_q.push_back({32'(a), mem_model[a / 4]});
        end
    endtask

    // ---------------- drivers ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_hit",   64'(mem_hit),   64'd0);
        chk("async_rst_fault", 64'(fault),     64'd0);
        exp_q.delete();
        push_seq(32'h0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] tgt, input bit legal);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        @(posedge clk);
        exp_q.delete();
        if (legal) push_seq(tgt);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_r1_valid", 64'(out_valid), 64'd0);
        chk("redir_r1_fault", 64'(fault),     64'd0);
        if (!legal) chk("redir_r1_nohit", 64'(mem_hit), 64'd0);
        @(negedge clk);
        chk("redir_r2_valid", 64'(out_valid), 64'd0);
        if (!legal) begin
            chk("redir_r2_fault", 64'(fault),   64'd1);
            chk("redir_r2_nohit", 64'(mem_hit), 64'd0);
        end
        @(negedge clk);
        if (legal) begin
            chk("redir_r3_valid", 64'(out_valid), 64'd1);
            chk("redir_r3_pc",    64'(out_pc),    64'(tgt));
        end else begin
            chk("redir_r3_valid", 64'(out_valid), 64'd0);
            chk("redir_r3_nohit", 64'(mem_hit),   64'd0);
        end
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && fault;
        end
        chk("drain_done", 64'(done), 64'd1);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got pc %0h with no expected entry at %0t", out_pc, $time);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("pop_pc",    64'(out_pc),    64'(e[63:32]));
                chk("pop_instr", 64'(out_instr), 64'(e[31:0]));
            end
            last_pc = out_pc;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int hits;
        logic [31:0] tgt;
        rst            = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_model[0] = 32'h11;
        mem_model[1] = 32'h22;
        mem_model[2] = 32'h33;
        mem_model[3] = 32'h44;
        for (int i = 4; i < MEM_WORDS; i++) mem_model[i] = $urandom;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_hit",   64'(mem_hit),   64'd0);
        chk("rst_fault", 64'(fault),     64'd0);
        chk("rst_addr",  64'(mem_addr),  64'd0);
        chk("rst_pc",    64'(out_pc),    64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));

        // Streaming from reset with decode always ready.
        push_seq(32'h0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        chk("idle_nohit", 64'(mem_hit), 64'd0);
        @(negedge clk);
        chk("first_hit",  64'(mem_hit),  64'd1);
        chk("first_addr", 64'(mem_addr), 64'd0);
        @(negedge clk);
        chk("lat_valid0", 64'(out_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_pc",    64'(out_pc),    64'(k * 4));
            chk("stream_instr", 64'(out_instr), 64'(32'h11 * (k + 1)));
        end

        // Backpressure from reset: only BUF_DEPTH reads may be outstanding.
        out_ready = 1'b0;
        do_reset();
        hits = 0;
        repeat (12) begin
            @(negedge clk);
            if (mem_hit) hits++;
        end
        chk("bp_hits",  64'(hits),      64'd3);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_pc",    64'(out_pc),    64'd0);
        chk("bp_nohit", 64'(mem_hit),   64'd0);

        // Run off the end of memory.
        rand_ready = 1'b1;
        wait_drain();
        chk("end_last_pc", 64'(last_pc), 64'd796);
        @(negedge clk);
        chk("end_fault", 64'(fault),     64'd1);
        chk("end_nohit", 64'(mem_hit),   64'd0);
        chk("end_state", 64'(dbg_state), 64'(ST_FAULT));
        redirect(32'h0, 1'b1);

        // Redirect with the buffer full.
        rand_ready = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("full_valid", 64'(out_valid), 64'd1);
        chk("full_nohit", 64'(mem_hit),   64'd0);
        redirect(32'h40, 1'b1);
        rand_ready = 1'b1;
        repeat (10) @(posedge clk);

        // Misaligned target faults without issuing.
        redirect(32'h6, 1'b0);
        repeat (3) @(posedge clk);
        redirect(32'h0, 1'b1);

        // Random redirects under random backpressure.
        repeat (15) begin
            repeat ($urandom_range(3, 40)) @(posedge clk);
            tgt = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
            redirect(tgt, 1'b1);
        end

        // Asynchronous reset mid-stream, then run to completion.
        repeat (5) @(posedge clk);
        do_reset();
        wait_drain();
        chk("final_last_pc", 64'(last_pc),       64'd796);
        chk("final_q_empty", 64'(exp_q.size()),  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
